// File: rtl/gb_apu_mixer_if.sv
// Mixer-facing bundle: channel levels and register fields in, mixed samples and PDM streams out.
// The APU core side takes the master modport and the mixer takes the slave modport.
interface gb_apu_mixer_if #(
  parameter int unsigned SAMPLE_W = 9
);
  logic [3:0]          ch1_level;
  logic [3:0]          ch2_level;
  logic [3:0]          ch3_level;
  logic [3:0]          ch4_level;
  logic [3:0]          ch_enable;
  logic                apu_enable;
  logic [7:0]          nr50;
  logic [7:0]          nr51;
  logic                sample_tick;
  logic [SAMPLE_W-1:0] left_sample;
  logic [SAMPLE_W-1:0] right_sample;
  logic                sample_valid;
  logic                pdm_left;
  logic                pdm_right;

  modport master (
    output ch1_level, ch2_level, ch3_level, ch4_level, ch_enable, apu_enable,
    output nr50, nr51, sample_tick,
    input  left_sample, right_sample, sample_valid, pdm_left, pdm_right
  );

  modport slave (
    input  ch1_level, ch2_level, ch3_level, ch4_level, ch_enable, apu_enable,
    input  nr50, nr51, sample_tick,
    output left_sample, right_sample, sample_valid, pdm_left, pdm_right
  );
endinterface

// File: rtl/gb_apu_mixer.sv
// Game Boy APU stereo mixer: gate/pan capture, per-side sum, NR50 scaling, optional 1-bit PDM.
// Define GB_APU_MIXER_PDM_EN to build the sigma-delta modulators; otherwise pdm_left/pdm_right are 0.
module gb_apu_mixer #(
  parameter int unsigned SAMPLE_W = 9
) (
  input  logic          clk,
  input  logic          reset,
  gb_apu_mixer_if.slave bus
);
  localparam int unsigned NCH   = 4;
  localparam int unsigned LVL_W = 4;
  localparam int unsigned SUM_W = 6;
  localparam int unsigned VOL_W = 3;
  localparam int unsigned ACC_W = 9;

  logic [NCH-1:0][LVL_W-1:0] lvl_c;
  assign lvl_c = {bus.ch4_level, bus.ch3_level, bus.ch2_level, bus.ch1_level};

  logic unused_c;
  assign unused_c = ^{bus.nr50[7], bus.nr50[3]};

  // Stage 1: gated levels and captured volumes
  logic [NCH-1:0][LVL_W-1:0] g_l_q, g_l_d, g_r_q, g_r_d;
  logic [VOL_W-1:0]          vol_l1_q, vol_l1_d, vol_r1_q, vol_r1_d;
  logic                      vld1_q, vld1_d;
  // Stage 2: per-side sums
  logic [SUM_W-1:0]          sum_l_q, sum_l_d, sum_r_q, sum_r_d;
  logic [SUM_W-1:0]          sum_l_c, sum_r_c;
  logic [VOL_W-1:0]          vol_l2_q, vol_l2_d, vol_r2_q, vol_r2_d;
  logic                      vld2_q, vld2_d;
  // Stage 3: scaled output samples
  logic [SAMPLE_W-1:0]       left_q, left_d, right_q, right_d;
  logic                      valid_q, valid_d;
  logic [VOL_W:0]            mul_l_c, mul_r_c;

  always_comb begin
    g_l_d    = g_l_q;
    g_r_d    = g_r_q;
    vol_l1_d = vol_l1_q;
    vol_r1_d = vol_r1_q;
    sum_l_d  = sum_l_q;
    sum_r_d  = sum_r_q;
    vol_l2_d = vol_l2_q;
    vol_r2_d = vol_r2_q;
    left_d   = left_q;
    right_d  = right_q;
    sum_l_c  = '0;
    sum_r_c  = '0;
    mul_l_c  = {1'b0, vol_l2_q} + (VOL_W + 1)'(1);
    mul_r_c  = {1'b0, vol_r2_q} + (VOL_W + 1)'(1);

    // Valid bits always advance so a lone strobe drains without further ticks
    vld1_d  = bus.sample_tick;
    vld2_d  = vld1_q;
    valid_d = vld2_q;

    if (bus.sample_tick) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        g_l_d[c] = (bus.apu_enable && bus.ch_enable[c] && bus.nr51[NCH + c]) ? lvl_c[c] : '0;
        g_r_d[c] = (bus.apu_enable && bus.ch_enable[c] && bus.nr51[c])       ? lvl_c[c] : '0;
      end
      vol_l1_d = bus.nr50[6:4];
      vol_r1_d = bus.nr50[2:0];
    end

    for (int unsigned c = 0; c < NCH; c++) begin
      sum_l_c = sum_l_c + SUM_W'(g_l_q[c]);
      sum_r_c = sum_r_c + SUM_W'(g_r_q[c]);
    end
    if (vld1_q) begin
      sum_l_d  = sum_l_c;
      sum_r_d  = sum_r_c;
      vol_l2_d = vol_l1_q;
      vol_r2_d = vol_r1_q;
    end

    // 60 * 8 = 480 fits in 9 bits, so no saturation
    if (vld2_q) begin
      left_d  = SAMPLE_W'(sum_l_q) * SAMPLE_W'(mul_l_c);
      right_d = SAMPLE_W'(sum_r_q) * SAMPLE_W'(mul_r_c);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      g_l_q    <= '0;
      g_r_q    <= '0;
      vol_l1_q <= '0;
      vol_r1_q <= '0;
      vld1_q   <= 1'b0;
      sum_l_q  <= '0;
      sum_r_q  <= '0;
      vol_l2_q <= '0;
      vol_r2_q <= '0;
      vld2_q   <= 1'b0;
      left_q   <= '0;
      right_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      g_l_q    <= g_l_d;
      g_r_q    <= g_r_d;
      vol_l1_q <= vol_l1_d;
      vol_r1_q <= vol_r1_d;
      vld1_q   <= vld1_d;
      sum_l_q  <= sum_l_d;
      sum_r_q  <= sum_r_d;
      vol_l2_q <= vol_l2_d;
      vol_r2_q <= vol_r2_d;
      vld2_q   <= vld2_d;
      left_q   <= left_d;
      right_q  <= right_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.left_sample  = left_q;
  assign bus.right_sample = right_q;
  assign bus.sample_valid = valid_q;

`ifdef GB_APU_MIXER_PDM_EN
  // First-order sigma-delta: carry out of a 9-bit accumulator gives density sample/512
  logic [ACC_W-1:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic             pdm_l_q, pdm_l_d, pdm_r_q, pdm_r_d;

  always_comb begin
    {pdm_l_d, acc_l_d} = {1'b0, acc_l_q} + (ACC_W + 1)'(left_q);
    {pdm_r_d, acc_r_d} = {1'b0, acc_r_q} + (ACC_W + 1)'(right_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_l_q <= '0;
      acc_r_q <= '0;
      pdm_l_q <= 1'b0;
      pdm_r_q <= 1'b0;
    end else begin
      acc_l_q <= acc_l_d;
      acc_r_q <= acc_r_d;
      pdm_l_q <= pdm_l_d;
      pdm_r_q <= pdm_r_d;
    end
  end

  assign bus.pdm_left  = pdm_l_q;
  assign bus.pdm_right = pdm_r_q;
`else
  assign bus.pdm_left  = 1'b0;
  assign bus.pdm_right = 1'b0;
`endif
endmodule

// File: tb/tb_gb_apu_mixer.sv
// Bench for gb_apu_mixer: vector table plus scoreboard of expected samples and arrival cycles.
module tb_gb_apu_mixer;
  localparam int unsigned SAMPLE_W = 9;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gb_apu_mixer_if #(.SAMPLE_W(SAMPLE_W)) mif ();
  gb_apu_mixer #(.SAMPLE_W(SAMPLE_W)) dut (.clk(clk), .reset(reset), .bus(mif));

  typedef struct {
    logic [3:0] l1, l2, l3, l4;
    logic [3:0] en;
    logic       apu;
    logic [7:0] nr50, nr51;
    int         exp_l, exp_r;
    string      name;
  } vec_t;

  typedef struct {
    int    l;
    int    r;
    int    cyc;
    string name;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[9];
  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Scoreboard monitor: every sample_valid must match the oldest pending expectation
  always @(negedge clk) begin
    if (reset && mif.sample_valid) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_valid: got valid at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_left"},    int'(mif.left_sample),  e.l);
        check({e.name, "_right"},   int'(mif.right_sample), e.r);
        check({e.name, "_latency"}, cyc,                    e.cyc);
      end
    end
  end

  task automatic set_inputs(input vec_t v);
    mif.ch1_level  = v.l1;
    mif.ch2_level  = v.l2;
    mif.ch3_level  = v.l3;
    mif.ch4_level  = v.l4;
    mif.ch_enable  = v.en;
    mif.apu_enable = v.apu;
    mif.nr50       = v.nr50;
    mif.nr51       = v.nr51;
  endtask

  // Tick sampled at the next edge; valid is seen at the negedge after two more edges
  task automatic drive_vec(input vec_t v);
    @(posedge clk); #1;
    set_inputs(v);
    mif.sample_tick = 1'b1;
    sb.push_back('{v.exp_l, v.exp_r, cyc + 3, v.name});
    @(posedge clk); #1;
    mif.sample_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic wait_valid(input string name);
    int k;
    for (k = 0; k < 10; k++) begin
      @(negedge clk);
      if (mif.sample_valid) break;
    end
    if (k == 10) begin
      checks++;
      $display("FAIL %s_timeout: got no valid expected valid within 10 cycles", name);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   ones;

    vecs[0] = '{4'd15, 4'd0,  4'd0, 4'd0,  4'h1, 1'b1, 8'h77, 8'h11, 120, 120, "single_ch1"};
    vecs[1] = '{4'd15, 4'd15, 4'd15, 4'd15, 4'hF, 1'b1, 8'h77, 8'hFF, 480, 480, "full_scale"};
    vecs[2] = '{4'd15, 4'd15, 4'd15, 4'd15, 4'hF, 1'b1, 8'h07, 8'hFF, 60,  480, "vol_asym"};
    vecs[3] = '{4'd15, 4'd15, 4'd15, 4'd15, 4'hF, 1'b1, 8'h8F, 8'hFF, 60,  480, "vin_bits"};
    vecs[4] = '{4'd15, 4'd15, 4'd15, 4'd15, 4'hF, 1'b1, 8'hF0, 8'hFF, 480, 60,  "vol_asym_r"};
    vecs[5] = '{4'd1,  4'd2,  4'd4,  4'd8,  4'hF, 1'b1, 8'h00, 8'hA5, 10,  5,   "panning"};
    vecs[6] = '{4'd1,  4'd2,  4'd4,  4'd8,  4'h0, 1'b1, 8'h00, 8'hA5, 0,   0,   "ch_disabled"};
    vecs[7] = '{4'd1,  4'd2,  4'd4,  4'd8,  4'hF, 1'b0, 8'h00, 8'hA5, 0,   0,   "apu_off"};
    vecs[8] = '{4'd5,  4'd9,  4'd3,  4'd12, 4'hB, 1'b1, 8'h52, 8'h3C, 84,  36,  "mixed"};

    set_inputs(vecs[0]);
    mif.sample_tick = 1'b0;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("reset_left",  int'(mif.left_sample),  0);
    check("reset_right", int'(mif.right_sample), 0);
    check("reset_valid", int'(mif.sample_valid), 0);
    check("reset_pdm",   int'({mif.pdm_left, mif.pdm_right}), 0);
    idle(2); #1;
    reset = 1'b1;

    for (int i = 0; i < 9; i++) begin
      drive_vec(vecs[i]);
      idle(4);
    end

`ifndef GB_APU_MIXER_PDM_EN
    drive_vec(vecs[1]);
    idle(3);
    ones = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      ones += int'(mif.pdm_left) + int'(mif.pdm_right);
    end
    check("pdm_disabled_ones", ones, 0);
`endif

    // Back-to-back strobes carrying 3, 7, 15
    v = '{4'd3, 4'd0, 4'd0, 4'd0, 4'h1, 1'b1, 8'h00, 8'h11, 0, 0, "b2b"};
    @(posedge clk); #1;
    set_inputs(v);
    mif.sample_tick = 1'b1;
    sb.push_back('{3, 3, cyc + 3, "b2b_0"});
    @(posedge clk); #1;
    mif.ch1_level = 4'd7;
    sb.push_back('{7, 7, cyc + 3, "b2b_1"});
    @(posedge clk); #1;
    mif.ch1_level = 4'd15;
    sb.push_back('{15, 15, cyc + 3, "b2b_2"});
    @(posedge clk); #1;
    mif.sample_tick = 1'b0;
    idle(5);

    // NR51/NR50 changed right after capture must not leak into the sample
    v = '{4'd9, 4'd0, 4'd0, 4'd0, 4'h1, 1'b1, 8'h00, 8'h11, 9, 9, "late_nr51"};
    drive_vec(v);
    mif.nr51 = 8'h00;
    mif.nr50 = 8'h77;
    idle(5);

    // Reset one cycle after a tick: in-flight sample is dropped
    drive_vec(vecs[0]);
    idle(4);
    @(posedge clk); #1;
    set_inputs(vecs[1]);
    mif.sample_tick = 1'b1;
    sb.push_back('{480, 480, cyc + 3, "lost"});
    @(posedge clk); #1;
    mif.sample_tick = 1'b0;
    reset = 1'b0;
    #1;
    check("async_rst_left",  int'(mif.left_sample),  0);
    check("async_rst_right", int'(mif.right_sample), 0);
    check("async_rst_valid", int'(mif.sample_valid), 0);
    sb.delete();
    idle(3); #1;
    reset = 1'b1;
    idle(6);
    drive_vec(vecs[5]);
    idle(4);

`ifdef GB_APU_MIXER_PDM_EN
    // 15+15+2 = 32, volume 7 -> 256: alternating stream from a cleared accumulator
    do_reset();
    v = '{4'd15, 4'd15, 4'd2, 4'd0, 4'h7, 1'b1, 8'h77, 8'h77, 256, 256, "pdm256"};
    @(posedge clk); #1;
    set_inputs(v);
    mif.sample_tick = 1'b1;
    sb.push_back('{256, 256, cyc + 3, "pdm256"});
    @(posedge clk); #1;
    mif.sample_tick = 1'b0;
    wait_valid("pdm256");
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check($sformatf("pdm256_l%0d", i), int'(mif.pdm_left),  i % 2);
      check($sformatf("pdm256_r%0d", i), int'(mif.pdm_right), i % 2);
    end

    do_reset();
    v = '{4'd0, 4'd0, 4'd0, 4'd0, 4'hF, 1'b1, 8'h77, 8'hFF, 0, 0, "pdm0"};
    drive_vec(v);
    wait_valid("pdm0");
    ones = 0;
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      ones += int'(mif.pdm_left) + int'(mif.pdm_right);
    end
    check("pdm0_ones", ones, 0);

    do_reset();
    drive_vec(vecs[1]);
    wait_valid("pdm480");
    ones = 0;
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      ones += int'(mif.pdm_left);
    end
    checks++;
    if (ones >= 479 && ones <= 481) passed++;
    else $display("FAIL pdm480_ones: got %0d expected 480+-1", ones);
`endif

    idle(4);
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
